nba_record_file: RTL and testbench
==================================

Name: nba_record_file

Overview:
- Parametrised array of DEPTH two-field records {foo, bar}, each field W bits.
- Two write ports with per-field enables and one registered read port.
- A sequenced bulk re-initialise walker restores every record to its init values.
- Sits in the regression-support library as the synthesizable successor to ad-hoc struct-array NBA checks. It gives a defined model for field-granular nonblocking updates: same-cycle visibility, port collisions and partial-field writes.

Parameters:
DEPTH, 2, number of records (>=2)
W, 32, width of each field in bits (1..64)
FOO_INIT, 0, foo value at reset / re-init (truncated to W)
BAR_INIT, 100, bar value at reset / re-init (truncated to W)
AW, $clog2(DEPTH), index width (localparam, derived)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
wa_en  in  1  write port A valid
wa_idx  in  AW  port A record index
wa_foo_en  in  1  port A writes foo
wa_bar_en  in  1  port A writes bar
wa_foo  in  W  port A foo data
wa_bar  in  W  port A bar data
wb_en, wb_idx, wb_foo_en, wb_bar_en, wb_foo, wb_bar  in  1/AW/1/1/W/W  write port B, same meaning
rd_en  in  1  read request
rd_idx  in  AW  read index
rd_valid  out  1  read data valid (1 cycle after accepted rd_en)
rd_foo  out  W  foo of read record
rd_bar  out  W  bar of read record
rd_err  out  1  read index out of range
init_req  in  1  start bulk re-initialise
busy  out  1  re-init walker active

Behaviour:
- Reset (rst=1 at edge):
  - All DEPTH records are set to {FOO_INIT, BAR_INIT} in that single cycle.
  - FSM goes to IDLE; walker pointer = 0.
  - busy, rd_valid, rd_err, rd_foo and rd_bar all go to 0.
  - Reset overrides every other input.
- Write: the record field updates at the clock edge where the port en and field enable are both 1. A field with its enable at 0 keeps its value (partial write).
- Read:
  - An accepted rd_en at edge N drives rd_valid=1 with the data during cycle N+1. Otherwise rd_valid is 0.
  - Data is the array contents before edge N's writes, so read-during-write returns the old value. The new value is visible to a read issued at edge N+1 or later.
- Collision:
  - Ports A and B on the same idx and same field with both enabled: B wins.
  - Same idx, different fields: both fields update.
  - Different idx: both records update.
- Out-of-range index (idx >= DEPTH, only possible when DEPTH is not a power of two):
  - A write to it is dropped with no side effect.
  - A read of it gives rd_valid=1, rd_err=1, rd_foo=0, rd_bar=0.
- FSM:
  - IDLE: if init_req=1, go to INIT with pointer=0 and busy=1 from the next cycle.
  - INIT: each cycle, record[pointer] is set to {FOO_INIT, BAR_INIT} and pointer increments. When pointer == DEPTH-1, that record is written and the FSM returns to IDLE with busy=0 next cycle. Total busy duration = DEPTH cycles.
  - While busy=1: write ports and rd_en are ignored (rd_valid stays 0), and init_req is ignored (no restart).
  - A write and init_req in the same IDLE cycle: the write takes effect at that edge; re-init then overwrites it.
- rst asserted mid-INIT: the walker aborts, all records are re-initialised at once, and busy=0 the next cycle.
- Field arithmetic: data is stored verbatim, W bits, with no sign handling. A negative literal input is its two's-complement W-bit pattern (-1 = all ones).

Test Plan:
- Reset, then read idx0 and idx1 -> rd_valid=1 next cycle; foo=0x00000000, bar=0x00000064 for both.
- Cycle 1: A writes idx0 {foo=0, bar=-0}, B writes idx1 {foo=1, bar=-1}; same-edge read of idx1 -> old {0, 0x64}. Read at next edge -> idx0 {0, 0}, idx1 {1, 0xFFFFFFFF}.
- Both ports write idx0 foo (A=0xAAAA, B=0x5555); A also writes bar=7 -> idx0 foo=0x5555, bar=7.
- Partial write: idx1 foo_en=1 only with foo=~1 -> idx1 {0xFFFFFFFE, 0xFFFFFFFF}; bar unchanged.
- init_req with DEPTH=2 -> busy=1 for exactly 2 cycles. A write offered during busy is dropped. After busy falls, all records read {0, 0x64}.
- DEPTH=3: read idx3 -> rd_err=1, data 0. Write idx3 -> no record changes. Assert rst mid-INIT -> busy=0 the next cycle and all records are at init values.

Source files
------------

// File: rtl/nba_record_file.sv
// Array of DEPTH {foo, bar} records with two field-granular write ports,
// a registered read port and a sequenced bulk re-initialise walker.
module nba_record_file #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned W        = 32,
  parameter logic [63:0] FOO_INIT = 64'd0,
  parameter logic [63:0] BAR_INIT = 64'd100,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_idx,
  input  logic          wa_foo_en,
  input  logic          wa_bar_en,
  input  logic [W-1:0]  wa_foo,
  input  logic [W-1:0]  wa_bar,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_idx,
  input  logic          wb_foo_en,
  input  logic          wb_bar_en,
  input  logic [W-1:0]  wb_foo,
  input  logic [W-1:0]  wb_bar,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [W-1:0]  rd_foo,
  output logic [W-1:0]  rd_bar,
  output logic          rd_err,
  input  logic          init_req,
  output logic          busy
);

  localparam logic [W-1:0]  FOO_INIT_W = FOO_INIT[W-1:0];
  localparam logic [W-1:0]  BAR_INIT_W = BAR_INIT[W-1:0];
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  foo_q [DEPTH];
  logic [W-1:0]  foo_d [DEPTH];
  logic [W-1:0]  bar_q [DEPTH];
  logic [W-1:0]  bar_d [DEPTH];
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;
  logic [W-1:0]  rd_foo_q, rd_foo_d;
  logic [W-1:0]  rd_bar_q, rd_bar_d;

  // Next-state: writes, read capture and re-init walker sequencing
  always_comb begin
    foo_d      = foo_q;
    bar_d      = bar_q;
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_foo_d   = {W{1'b0}};
    rd_bar_d   = {W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        // Port B is applied after A so it wins a same-field collision;
        // out-of-range indices match no record and are dropped.
        for (int i = 0; i < DEPTH; i++) begin
          foo_d[i] = (wa_en && wa_foo_en && (wa_idx == AW'(i))) ? wa_foo : foo_d[i];
          bar_d[i] = (wa_en && wa_bar_en && (wa_idx == AW'(i))) ? wa_bar : bar_d[i];
          foo_d[i] = (wb_en && wb_foo_en && (wb_idx == AW'(i))) ? wb_foo : foo_d[i];
          bar_d[i] = (wb_en && wb_bar_en && (wb_idx == AW'(i))) ? wb_bar : bar_d[i];
          rd_foo_d = (rd_en && (rd_idx == AW'(i))) ? foo_q[i] : rd_foo_d;
          rd_bar_d = (rd_en && (rd_idx == AW'(i))) ? bar_q[i] : rd_bar_d;
        end
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && ({1'b0, rd_idx} >= DEPTH_C);
        if (init_req) begin
          state_d = ST_INIT;
          ptr_d   = {AW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        for (int i = 0; i < DEPTH; i++) begin
          foo_d[i] = (ptr_q == AW'(i)) ? FOO_INIT_W : foo_d[i];
          bar_d[i] = (ptr_q == AW'(i)) ? BAR_INIT_W : bar_d[i];
        end
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = {AW{1'b0}};
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // State registers; reset restores every record at once
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        foo_q[i] <= FOO_INIT_W;
        bar_q[i] <= BAR_INIT_W;
      end
      state_q    <= ST_IDLE;
      ptr_q      <= {AW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_foo_q   <= {W{1'b0}};
      rd_bar_q   <= {W{1'b0}};
    end else begin
      foo_q      <= foo_d;
      bar_q      <= bar_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_foo_q   <= rd_foo_d;
      rd_bar_q   <= rd_bar_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_foo   = rd_foo_q;
  assign rd_bar   = rd_bar_q;
  assign busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_nba_record_file.sv
// Scoreboard bench: a DEPTH=2 and a DEPTH=3 instance driven by directed vectors;
// monitors pop expected read responses whenever rd_valid is seen.
module tb_nba_record_file;

  typedef struct packed {
    logic        err;
    logic [31:0] foo;
    logic [31:0] bar;
  } rec_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  rec_t exp2 [$];
  rec_t exp3 [$];

  logic        rst2, a2_en, a2_fe, a2_be, b2_en, b2_fe, b2_be, r2_en, i2_req;
  logic [0:0]  a2_idx, b2_idx, r2_idx;
  logic [31:0] a2_foo, a2_bar, b2_foo, b2_bar;
  logic        v2, e2, busy2;
  logic [31:0] f2, g2;

  logic        rst3, a3_en, a3_fe, a3_be, b3_en, b3_fe, b3_be, r3_en, i3_req;
  logic [1:0]  a3_idx, b3_idx, r3_idx;
  logic [31:0] a3_foo, a3_bar, b3_foo, b3_bar;
  logic        v3, e3, busy3;
  logic [31:0] f3, g3;

  nba_record_file u_dut2 (
    .clk(clk), .rst(rst2),
    .wa_en(a2_en), .wa_idx(a2_idx), .wa_foo_en(a2_fe), .wa_bar_en(a2_be),
    .wa_foo(a2_foo), .wa_bar(a2_bar),
    .wb_en(b2_en), .wb_idx(b2_idx), .wb_foo_en(b2_fe), .wb_bar_en(b2_be),
    .wb_foo(b2_foo), .wb_bar(b2_bar),
    .rd_en(r2_en), .rd_idx(r2_idx), .rd_valid(v2), .rd_foo(f2), .rd_bar(g2),
    .rd_err(e2), .init_req(i2_req), .busy(busy2)
  );

  nba_record_file #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .wa_en(a3_en), .wa_idx(a3_idx), .wa_foo_en(a3_fe), .wa_bar_en(a3_be),
    .wa_foo(a3_foo), .wa_bar(a3_bar),
    .wb_en(b3_en), .wb_idx(b3_idx), .wb_foo_en(b3_fe), .wb_bar_en(b3_be),
    .wb_foo(b3_foo), .wb_bar(b3_bar),
    .rd_en(r3_en), .rd_idx(r3_idx), .rd_valid(v3), .rd_foo(f3), .rd_bar(g3),
    .rd_err(e3), .init_req(i3_req), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: every rd_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (v2 === 1'b1) begin
      if (exp2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd2_unexpected actual_valid=1 required_valid=0");
      end else begin
        chk("rd2_data", {e2, f2, g2}, exp2.pop_front());
      end
    end
    if (v3 === 1'b1) begin
      if (exp3.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd3_unexpected actual_valid=1 required_valid=0");
      end else begin
        chk("rd3_data", {e3, f3, g3}, exp3.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    a2_en = 1'b0; a2_fe = 1'b0; a2_be = 1'b0; a2_idx = 1'b0; a2_foo = 32'd0; a2_bar = 32'd0;
    b2_en = 1'b0; b2_fe = 1'b0; b2_be = 1'b0; b2_idx = 1'b0; b2_foo = 32'd0; b2_bar = 32'd0;
    r2_en = 1'b0; r2_idx = 1'b0; i2_req = 1'b0;
    a3_en = 1'b0; a3_fe = 1'b0; a3_be = 1'b0; a3_idx = 2'd0; a3_foo = 32'd0; a3_bar = 32'd0;
    b3_en = 1'b0; b3_fe = 1'b0; b3_be = 1'b0; b3_idx = 2'd0; b3_foo = 32'd0; b3_bar = 32'd0;
    r3_en = 1'b0; r3_idx = 2'd0; i3_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic rd2(input logic idx, input logic [31:0] foo, input logic [31:0] bar);
    r2_en = 1'b1; r2_idx = idx;
    exp2.push_back('{1'b0, foo, bar});
  endtask

  task automatic rd3(input logic [1:0] idx, input logic e, input logic [31:0] foo, input logic [31:0] bar);
    r3_en = 1'b1; r3_idx = idx;
    exp3.push_back('{e, foo, bar});
  endtask

  initial begin
    int cnt;
    clear_inputs();
    rst2 = 1'b1; rst3 = 1'b1;
    tick(); tick();
    rst2 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("reset2_outputs", {61'd0, v2, e2, busy2, |{f2, g2}}, 65'd0);
    chk("reset3_outputs", {61'd0, v3, e3, busy3, |{f3, g3}}, 65'd0);

    // Reset contents
    rd2(1'b0, 32'h0, 32'h64); tick();
    rd2(1'b1, 32'h0, 32'h64); tick();

    // Two ports to different records, same-edge read returns old data
    a2_en = 1'b1; a2_idx = 1'b0; a2_fe = 1'b1; a2_be = 1'b1; a2_foo = 32'd0; a2_bar = -32'sd0;
    b2_en = 1'b1; b2_idx = 1'b1; b2_fe = 1'b1; b2_be = 1'b1; b2_foo = 32'd1; b2_bar = -32'sd1;
    rd2(1'b1, 32'h0, 32'h64); tick();
    rd2(1'b0, 32'h0, 32'h0); tick();
    rd2(1'b1, 32'h1, 32'hFFFF_FFFF); tick();

    // Same-field collision: B wins foo, A's bar lands
    a2_en = 1'b1; a2_idx = 1'b0; a2_fe = 1'b1; a2_be = 1'b1; a2_foo = 32'hAAAA; a2_bar = 32'd7;
    b2_en = 1'b1; b2_idx = 1'b0; b2_fe = 1'b1; b2_be = 1'b0; b2_foo = 32'h5555; b2_bar = 32'd9;
    tick();
    rd2(1'b0, 32'h5555, 32'h7); tick();

    // Partial write leaves bar alone
    a2_en = 1'b1; a2_idx = 1'b1; a2_fe = 1'b1; a2_be = 1'b0; a2_foo = ~32'd1; a2_bar = 32'h1234;
    tick();
    rd2(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF); tick();

    // Same index, different fields from each port
    a2_en = 1'b1; a2_idx = 1'b0; a2_fe = 1'b1; a2_foo = 32'h11;
    b2_en = 1'b1; b2_idx = 1'b0; b2_be = 1'b1; b2_bar = 32'h22;
    tick();
    rd2(1'b0, 32'h11, 32'h22); tick();

    // Re-init with a same-cycle write; activity during busy must be ignored
    a2_en = 1'b1; a2_idx = 1'b1; a2_fe = 1'b1; a2_foo = 32'h99;
    i2_req = 1'b1;
    tick();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy2) begin
        cnt++;
        a2_en = 1'b1; a2_idx = 1'b0; a2_fe = 1'b1; a2_be = 1'b1; a2_foo = 32'hDEAD; a2_bar = 32'hBEEF;
        r2_en = 1'b1; r2_idx = 1'b0; i2_req = 1'b1;
      end else begin
        clear_inputs();
      end
    end
    chk("busy2_cycles", 65'(cnt), 65'd2);
    rd2(1'b0, 32'h0, 32'h64); tick();
    rd2(1'b1, 32'h0, 32'h64); tick();

    // DEPTH=3: out-of-range read and write
    rd3(2'd3, 1'b1, 32'h0, 32'h0); tick();
    a3_en = 1'b1; a3_idx = 2'd3; a3_fe = 1'b1; a3_be = 1'b1; a3_foo = 32'hBAD; a3_bar = 32'hBAD;
    b3_en = 1'b1; b3_idx = 2'd3; b3_fe = 1'b1; b3_be = 1'b1; b3_foo = 32'hBAD; b3_bar = 32'hBAD;
    tick();
    rd3(2'd0, 1'b0, 32'h0, 32'h64); tick();
    rd3(2'd1, 1'b0, 32'h0, 32'h64); tick();
    rd3(2'd2, 1'b0, 32'h0, 32'h64); tick();

    // Reset mid-walk restores every record, including ones not yet walked
    a3_en = 1'b1; a3_idx = 2'd2; a3_fe = 1'b1; a3_be = 1'b1; a3_foo = 32'd5; a3_bar = 32'd6;
    tick();
    rd3(2'd2, 1'b0, 32'd5, 32'd6); tick();
    i3_req = 1'b1; tick();
    tick();
    @(negedge clk);
    chk("busy3_mid_init", {64'd0, busy3}, 65'd1);
    rst3 = 1'b1; tick();
    rst3 = 1'b0;
    @(negedge clk);
    chk("busy3_after_rst", {64'd0, busy3}, 65'd0);
    rd3(2'd2, 1'b0, 32'h0, 32'h64); tick();
    rd3(2'd0, 1'b0, 32'h0, 32'h64); tick();
    rd3(2'd1, 1'b0, 32'h0, 32'h64); tick();

    tick(); tick();
    chk("exp2_drained", 65'(exp2.size()), 65'd0);
    chk("exp3_drained", 65'(exp3.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
